// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types, segment patterns and helpers for the seven-segment scan controller.
package seven_seg_scan_ctrl_pkg;

    typedef enum logic [0:0] {StBlank, StShow} scan_state_e;

    // Active-high abc_defg, bit 6 = segment a.
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h73;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_decode(input logic [3:0] i_val);
        logic [6:0] w_seg;
        case (i_val)
            4'd0:    w_seg = SEG_0;
            4'd1:    w_seg = SEG_1;
            4'd2:    w_seg = SEG_2;
            4'd3:    w_seg = SEG_3;
            4'd4:    w_seg = SEG_4;
            4'd5:    w_seg = SEG_5;
            4'd6:    w_seg = SEG_6;
            4'd7:    w_seg = SEG_7;
            4'd8:    w_seg = SEG_8;
            4'd9:    w_seg = SEG_9;
            default: w_seg = SEG_BLANK;
        endcase
        return w_seg;
    endfunction

    function automatic int idx_width(input int num_digits);
        return (num_digits > 1) ? $clog2(num_digits) : 1;
    endfunction

    function automatic int cnt_width(input int show_cycles, input int blank_cycles);
        return $clog2(((show_cycles > blank_cycles) ? show_cycles : blank_cycles) + 1);
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Write/enable inputs and display outputs of the seven-segment scan controller.
interface seven_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    wr_en;
    logic [4*NUM_DIGITS-1:0] wr_data;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic [6:0]              segments;
    logic                    frame_done;

    modport master (
        output wr_en, wr_data, digit_en,
        input  digit_sel, segments, frame_done
    );

    modport slave (
        input  wr_en, wr_data, digit_en,
        output digit_sel, segments, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_ctrl_timer.sv
// Slot timing for the scan controller: BLANK/SHOW FSM, cycle counter and digit index.
// Strobes are derived from next-state values so the top can register its outputs in step.
module seven_seg_scan_ctrl_timer
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SHOW_CYCLES  = 1000,
    parameter int BLANK_CYCLES = 8,
    localparam int IdxW        = idx_width(NUM_DIGITS)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    output logic            o_load,
    output logic            o_clear,
    output logic [IdxW-1:0] o_idx,
    output logic            o_frame_done
);

    localparam int CntW = cnt_width(SHOW_CYCLES, BLANK_CYCLES);
    localparam logic [CntW-1:0] ShowLast  = CntW'(SHOW_CYCLES - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

    scan_state_e     r_state, w_state_n;
    logic [CntW-1:0] r_cnt, w_cnt_n;
    logic [IdxW-1:0] r_idx, w_idx_n;
    logic            r_frame_done, w_frame_done_n;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StBlank;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_cnt        <= w_cnt_n;
            r_idx        <= w_idx_n;
            r_frame_done <= w_frame_done_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + 1'b1;
        w_idx_n   = r_idx;
        unique case (r_state)
            StBlank: begin
                if (BLANK_CYCLES == 0 || r_cnt == BlankLast) begin
                    w_state_n = StShow;
                    w_cnt_n   = '0;
                end
            end
            StShow: begin
                if (r_cnt == ShowLast) begin
                    // With no blanking the next slot starts straight away.
                    w_state_n = (BLANK_CYCLES == 0) ? StShow : StBlank;
                    w_cnt_n   = '0;
                    w_idx_n   = (r_idx == IdxLast) ? '0 : r_idx + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        o_load         = (w_state_n == StShow) && (w_cnt_n == '0);
        o_clear        = (w_state_n == StBlank);
        o_idx          = w_idx_n;
        w_frame_done_n = (w_state_n == StShow) && (w_cnt_n == ShowLast) && (w_idx_n == IdxLast);
    end

    assign o_frame_done = r_frame_done;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed N-digit seven-segment scan controller with frame-atomic digit buffer.
// Optional SEG_LEADING_ZERO_BLANK_EN suppresses leading zeros (digit 0 always shown).
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SHOW_CYCLES  = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input logic                  i_clk,
    input logic                  i_reset,
    seven_seg_scan_ctrl_if.slave io_bus
);

    localparam int IdxW  = idx_width(NUM_DIGITS);
    localparam int DataW = 4 * NUM_DIGITS;

    logic [DataW-1:0]      r_pending, r_active, w_active_n;
    logic [NUM_DIGITS-1:0] r_digit_sel, w_sel_n, w_blank;
    logic [6:0]            r_segments, w_seg_n;
    logic [3:0]            w_nib;
    logic [IdxW-1:0]       w_idx;
    logic                  w_load, w_clear, w_frame_done;

    seven_seg_scan_ctrl_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SHOW_CYCLES (SHOW_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .o_load      (w_load),
        .o_clear     (w_clear),
        .o_idx       (w_idx),
        .o_frame_done(w_frame_done)
    );

    // A write landing on the boundary cycle is committed directly, not one frame late.
    assign w_active_n = w_frame_done ? (io_bus.wr_en ? io_bus.wr_data : r_pending) : r_active;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic w_above_dark;
`endif

    always_comb begin
        w_blank = '0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        w_above_dark = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_blank[i]   = w_above_dark && (w_active_n[4*i +: 4] == 4'd0);
            w_above_dark = w_above_dark &&
                           (w_active_n[4*i +: 4] == 4'd0 || w_active_n[4*i +: 4] > 4'd9);
        end
`endif
    end

    always_comb begin
        w_nib   = 4'd0;
        w_sel_n = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx == IdxW'(i)) begin
                w_nib      = w_active_n[4*i +: 4];
                w_sel_n[i] = io_bus.digit_en[i] && !w_blank[i];
            end
        end
        w_seg_n = (|w_sel_n) ? seg_decode(w_nib) : SEG_BLANK;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pending   <= '0;
            r_active    <= '0;
            r_digit_sel <= '0;
            r_segments  <= '0;
        end else begin
            if (io_bus.wr_en) begin
                r_pending <= io_bus.wr_data;
            end
            if (w_frame_done) begin
                r_active <= w_active_n;
            end
            if (w_load) begin
                r_digit_sel <= w_sel_n;
                r_segments  <= w_seg_n;
            end else if (w_clear) begin
                r_digit_sel <= '0;
                r_segments  <= '0;
            end
        end
    end

    assign io_bus.digit_sel  = r_digit_sel;
    assign io_bus.segments   = r_segments;
    assign io_bus.frame_done = w_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Frame-by-frame vector bench for seven_seg_scan_ctrl (4 digits, 4 lit / 2 blank cycles).
module tb_seven_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int SHOW  = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = SHOW + BLANK;
    localparam int FRAME = N * SLOT;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam bit Lz = 1'b1;
`else
    localparam bit Lz = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seven_seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .SHOW_CYCLES (SHOW),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .io_bus (bus)
    );

    // One record per frame: writes applied at positions wr_lo..wr_hi, enables, and the
    // digits expected on screen during this frame (lit mask + patterns, digit 3 first).
    typedef struct {
        int          wr_lo;
        int          wr_hi;
        logic [15:0] wr_data;
        logic [3:0]  en;
        logic [3:0]  lit;
        logic [27:0] segs;
    } vec_t;

    vec_t vecs [10];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Entered on the negedge of frame position 0; returns on the negedge after last_pos.
    task automatic run_frame(input int v, input int last_pos);
        logic [3:0] e_sel;
        logic [6:0] e_seg;
        int         slot;
        for (int p = 0; p <= last_pos; p++) begin
            slot  = p / SLOT;
            e_sel = '0;
            e_seg = '0;
            if ((p % SLOT) >= BLANK && vecs[v].lit[slot]) begin
                e_sel[slot] = 1'b1;
                e_seg       = vecs[v].segs[7*slot +: 7];
            end
            check($sformatf("v%0d p%0d digit_sel", v, p), 32'(bus.digit_sel), 32'(e_sel));
            check($sformatf("v%0d p%0d segments", v, p), 32'(bus.segments), 32'(e_seg));
            check($sformatf("v%0d p%0d frame_done", v, p), 32'(bus.frame_done),
                  32'(p == FRAME - 1));
            bus.digit_en = vecs[v].en;
            bus.wr_en    = (p >= vecs[v].wr_lo) && (p <= vecs[v].wr_hi);
            bus.wr_data  = bus.wr_en ? vecs[v].wr_data : 16'hDEAD;
            @(negedge clk);
        end
    endtask

    initial begin
        vecs[0] = '{0, 23, 16'h4321, 4'hF, Lz ? 4'h1 : 4'hF, {7'h7E, 7'h7E, 7'h7E, 7'h7E}};
        vecs[1] = '{1, 0, 16'h0000, 4'h5, 4'h5, {7'h33, 7'h79, 7'h6D, 7'h30}};
        vecs[2] = '{0, 23, 16'h0050, 4'hF, 4'hF, {7'h33, 7'h79, 7'h6D, 7'h30}};
        vecs[3] = '{0, 23, 16'h0000, 4'hF, Lz ? 4'h3 : 4'hF, {7'h7E, 7'h7E, 7'h5B, 7'h7E}};
        vecs[4] = '{0, 23, 16'h1A21, 4'hF, Lz ? 4'h1 : 4'hF, {7'h7E, 7'h7E, 7'h7E, 7'h7E}};
        vecs[5] = '{10, 10, 16'h9999, 4'hF, 4'hF, {7'h30, 7'h00, 7'h6D, 7'h30}};
        vecs[6] = '{23, 23, 16'h0008, 4'hF, 4'hF, {7'h73, 7'h73, 7'h73, 7'h73}};
        vecs[7] = '{1, 0, 16'h0000, 4'hF, Lz ? 4'h1 : 4'hF, {7'h7E, 7'h7E, 7'h7E, 7'h7F}};
        vecs[8] = '{1, 0, 16'h0000, 4'hF, Lz ? 4'h1 : 4'hF, {7'h7E, 7'h7E, 7'h7E, 7'h7F}};
        vecs[9] = '{1, 0, 16'h0000, 4'hF, Lz ? 4'h1 : 4'hF, {7'h7E, 7'h7E, 7'h7E, 7'h7E}};

        bus.wr_en    = 1'b0;
        bus.wr_data  = '0;
        bus.digit_en = '1;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        check("reset digit_sel", 32'(bus.digit_sel), 32'h0);
        check("reset segments", 32'(bus.segments), 32'h0);
        check("reset frame_done", 32'(bus.frame_done), 32'h0);

        // Release on a negedge: this sample is frame position 0.
        rst = 1'b0;
        for (int v = 0; v < 8; v++) begin
            run_frame(v, FRAME - 1);
        end

        // Abort in the middle of digit 2's lit period.
        run_frame(8, 15);
        rst = 1'b1;
        @(negedge clk);
        check("mid-show reset digit_sel", 32'(bus.digit_sel), 32'h0);
        check("mid-show reset segments", 32'(bus.segments), 32'h0);
        check("mid-show reset frame_done", 32'(bus.frame_done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_frame(9, FRAME - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
